// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared types and constants for the AES round controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } aes_ctrl_state_t;

    localparam int AES128_ROUNDS = 10;

    typedef logic [127:0] aes_block_t;

endpackage
`default_nettype wire

// File: rtl/aes_round_counter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_counter
//  Description : Round counter with clear, increment and terminal-count flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_counter #(
    parameter int RW       = 4,
    parameter int TC_VALUE = 9
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [RW-1:0] o_cnt,
    output logic          o_tc
);

    localparam logic [RW-1:0] c_tc_value = RW'(TC_VALUE);

    logic [RW-1:0] r_cnt;

    // Clear wins over increment so an abort or a new block always restarts at 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + RW'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == c_tc_value);

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl
//  Description : Round sequencer for the AES-128/192/256 encryption datapath.
//                Define AES_CTRL_ABORT_EN to add the abort input.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int RW         = 4
) (
    input  logic          clk,
    input  logic          n_rst,
`ifdef AES_CTRL_ABORT_EN
    input  logic          abort,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    output logic          key_req,
    output logic [RW-1:0] key_idx,
    input  logic          key_ack,
    output logic          init_sel,
    output logic          state_en,
    output logic          mix_en,
    output logic [RW-1:0] round_cnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    localparam logic [RW-1:0] c_last_key = RW'(NUM_ROUNDS);

    aes_ctrl_state_t r_state;
    aes_ctrl_state_t w_next_state;
    logic            w_abort;
    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic            w_tc;

`ifdef AES_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    aes_round_counter #(
        .RW       (RW),
        .TC_VALUE (NUM_ROUNDS - 1)
    ) u_round_counter (
        .clk   (clk),
        .n_rst (n_rst),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_cnt (round_cnt),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        in_ready     = 1'b0;
        key_req      = 1'b0;
        key_idx      = '0;
        init_sel     = 1'b0;
        mix_en       = 1'b0;
        out_valid    = 1'b0;
        busy         = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = INIT;
                    w_cnt_clr    = 1'b1;
                end
            end
            INIT: begin
                key_req  = 1'b1;
                init_sel = 1'b1;
                if (key_ack) begin
                    w_cnt_inc    = 1'b1;
                    w_next_state = (NUM_ROUNDS == 1) ? FINAL : ROUND;
                end
            end
            ROUND: begin
                key_req = 1'b1;
                key_idx = round_cnt;
                mix_en  = 1'b1;
                if (key_ack) begin
                    w_cnt_inc = 1'b1;
                    if (w_tc) begin
                        w_next_state = FINAL;
                    end
                end
            end
            FINAL: begin
                key_req = 1'b1;
                key_idx = c_last_key;
                if (key_ack) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                    w_cnt_clr    = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_cnt_clr    = 1'b1;
            end
        endcase

        // Abort overrides every transition taken above, including the counter.
        if (w_abort && (r_state != IDLE)) begin
            w_next_state = IDLE;
            w_cnt_clr    = 1'b1;
            w_cnt_inc    = 1'b0;
        end

        state_en = key_ack && key_req && !w_abort;
    end

endmodule
`default_nettype wire
